// File: rtl/multibyte_adder_seq.sv
// Sequential multi-precision adder/subtractor: streams NBYTES-wide operands
// LSB-first through a single 8-bit ripple-carry adder, one byte per clock.
module multibyte_adder_seq #(
    parameter int NBYTES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [8*NBYTES-1:0] op_a,
    input  logic [8*NBYTES-1:0] op_b,
    input  logic                cin,
    input  logic                sub,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [8*NBYTES-1:0] sum,
    output logic                cout,
    output logic                overflow
);

    localparam int W  = 8 * NBYTES;
    localparam int IW = $clog2(NBYTES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic           carry_q, carry_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [W-1:0]   work_q, work_d;
    logic [W-1:0]   sum_q, sum_d;
    logic           cout_q, cout_d;
    logic           ovf_q, ovf_d;

    logic [7:0]     rca_a_s;
    logic [7:0]     rca_b_s;
    logic [8:0]     rca_s_s;
    logic [W-1:0]   work_ins_s;

    assign rca_a_s = 8'(a_q >> {idx_q, 3'b000});
    assign rca_b_s = 8'(b_q >> {idx_q, 3'b000});

    rca_2op_8bit u_rca (
        .a_i   (rca_a_s),
        .b_i   (rca_b_s),
        .cin_i (carry_q),
        .s_o   (rca_s_s)
    );

    // Work word with the current byte replaced by this cycle's adder result.
    always_comb begin
        work_ins_s = work_q;
        for (int i = 0; i < NBYTES; i++) begin
            if (idx_q == IW'(i)) begin
                work_ins_s[i*8 +: 8] = rca_s_s[7:0];
            end else begin
                work_ins_s[i*8 +: 8] = work_q[i*8 +: 8];
            end
        end
    end

    // Next-state and datapath update for the IDLE -> RUN -> DONE sequence.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        work_d  = work_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = op_a;
                    b_d     = sub ? ~op_b : op_b;
                    carry_d = sub ? 1'b1 : cin;
                    idx_d   = {IW{1'b0}};
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                work_d  = work_ins_s;
                carry_d = rca_s_s[8];
                if (idx_q == IW'(NBYTES - 1)) begin
                    // Top byte: its sign bit is the adder's bit 7.
                    idx_d   = {IW{1'b0}};
                    sum_d   = work_ins_s;
                    cout_d  = rca_s_s[8];
                    ovf_d   = (a_q[W-1] == b_q[W-1]) && (rca_s_s[7] != a_q[W-1]);
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + IW'(1);
                    state_d = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= {W{1'b0}};
            b_q     <= {W{1'b0}};
            carry_q <= 1'b0;
            idx_q   <= {IW{1'b0}};
            work_q  <= {W{1'b0}};
            sum_q   <= {W{1'b0}};
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            work_q  <= work_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;

endmodule

// 8-bit two-operand ripple-carry adder; s_o[8] is the carry-out.
module rca_2op_8bit (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic       cin_i,
    output logic [8:0] s_o
);

    logic c_s;

    // Bit-serial carry chain.
    always_comb begin
        s_o = 9'b0;
        c_s = cin_i;
        for (int i = 0; i < 8; i++) begin
            s_o[i] = a_i[i] ^ b_i[i] ^ c_s;
            c_s    = (a_i[i] & b_i[i]) | (c_s & (a_i[i] ^ b_i[i]));
        end
        s_o[8] = c_s;
    end

endmodule

// File: tb/tb_multibyte_adder_seq.sv
// Self-checking bench for multibyte_adder_seq: directed corner cases plus
// randomized back-to-back traffic against an arithmetic reference model.
module tb_multibyte_adder_seq;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
    } op_t;

    op_t q[$];

    always #5 clk = ~clk;

    multibyte_adder_seq #(.NBYTES(NB)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: returns {overflow, cout, sum} from plain integer arithmetic.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic c, input logic s);
        logic [W:0] u;
        longint     sa;
        longint     sb;
        longint     r;
        logic       ov;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (s) begin
            u = {1'b0, a} + ({1'b0, ~b} + 33'd1);
            r = sa - sb;
        end else begin
            u = {1'b0, a} + {1'b0, b} + {32'd0, c};
            r = sa + sb + longint'(c);
        end
        ov = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        return {ov, u};
    endfunction

    function automatic logic [W-1:0] rnd_word();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // One operation; hold>0 keeps out_ready low that many cycles while
    // driving junk operands with in_valid high.
    task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c, input logic s, input int hold);
        logic [W+1:0] e;
        int n;
        e = model(a, b, c, s);
        op_a = a; op_b = b; cin = c; sub = s; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check_eq({tag, "_accept"}, 64'(n < 20), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        op_a = $urandom; op_b = $urandom; cin = ~c; sub = ~s;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check_eq({tag, "_latency"}, 64'(n), 64'(NB));
        check_eq({tag, "_sum"}, 64'(sum), 64'(e[W-1:0]));
        check_eq({tag, "_cout"}, 64'(cout), 64'(e[W]));
        check_eq({tag, "_ovf"}, 64'(overflow), 64'(e[W+1]));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; op_a = $urandom; op_b = $urandom;
            @(posedge clk); #1;
            check_eq({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
            check_eq({tag, "_hold_ready"}, 64'(in_ready), 64'd0);
            check_eq({tag, "_hold_res"}, 64'({overflow, cout, sum}), 64'(e));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq({tag, "_idle_valid"}, 64'(out_valid), 64'd0);
        check_eq({tag, "_idle_ready"}, 64'(in_ready), 64'd1);
        check_eq({tag, "_idle_res"}, 64'({overflow, cout, sum}), 64'(e));
    endtask

    initial begin
        logic [W+1:0] e;
        op_t o;
        int cyc;
        int last;
        int accepts;
        int n;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op_a = '0; op_b = '0; cin = 1'b0; sub = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check_eq("rst_in_ready", 64'(in_ready), 64'd0);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_res", 64'({overflow, cout, sum}), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check_eq("post_rst_in_ready", 64'(in_ready), 64'd1);

        do_op("t1_ripple", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0);
        do_op("t2_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0);
        do_op("t2_cin", 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 0);
        do_op("t3_borrow", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 0);
        do_op("t4_bp", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 5);
        do_op("t4_after", 32'h0F0F_0F0F, 32'hF0F0_F0F1, 1'b0, 1'b0, 0);

        // Reset during the second RUN cycle.
        op_a = 32'hAAAA_AAAA; op_b = 32'h5555_5555; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check_eq("t5_valid", 64'(out_valid), 64'd0);
        check_eq("t5_res", 64'({overflow, cout, sum}), 64'd0);
        check_eq("t5_ready_in_rst", 64'(in_ready), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check_eq("t5_ready", 64'(in_ready), 64'd1);
        check_eq("t5_valid2", 64'(out_valid), 64'd0);
        do_op("t5_add", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 0);
        check_eq("t5_sum_const", 64'(sum), 64'h100);

        // Back-to-back traffic with both handshakes tied high.
        in_valid = 1'b1; out_ready = 1'b1;
        cyc = 0; last = -1; accepts = 0;
        while (accepts < 10 && cyc < 300) begin
            op_a = rnd_word(); op_b = rnd_word();
            cin = 1'($urandom); sub = 1'($urandom);
            @(negedge clk);
            if (out_valid) begin
                if (q.size() > 0) begin
                    o = q.pop_front();
                    e = model(o.a, o.b, o.cin, o.sub);
                    check_eq("t6_res", 64'({overflow, cout, sum}), 64'(e));
                end else begin
                    check_eq("t6_unexpected", 64'd1, 64'd0);
                end
            end
            if (in_ready) begin
                q.push_back('{a: op_a, b: op_b, cin: cin, sub: sub});
                if (last >= 0) check_eq("t6_ii", 64'(cyc - last), 64'(NB + 2));
                last = cyc;
                accepts++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        check_eq("t6_accepts", 64'(accepts), 64'd10);
        in_valid = 1'b0;
        n = 0;
        while (q.size() > 0 && n < 20) begin
            @(negedge clk);
            if (out_valid) begin
                o = q.pop_front();
                e = model(o.a, o.b, o.cin, o.sub);
                check_eq("t6_drain", 64'({overflow, cout, sum}), 64'(e));
            end
            @(posedge clk); #1;
            n++;
        end
        check_eq("t6_drained", 64'(q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multibyte_adder_seq.md
Name: multibyte_adder_seq

Overview:
Sequential multi-precision adder/subtractor that splits two NBYTES-wide operands into bytes and feeds them LSB-first through one internal rca_2op_8bit instance, one byte per clock. Each cycle's carry-out S[8] is registered and fed back as the next byte's Cin. The block sits directly upstream of the 8-bit ripple-carry adder and consumes its 9-bit result. It lets wide additions reuse a single 8-bit datapath, and it presents valid/ready handshakes on both the operand and result sides.

Parameters:
NBYTES, 4, operand width in bytes (>=2); data width W = 8*NBYTES

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  reset, synchronous, active-high
in_valid  input  1  operand request valid
in_ready  output  1  block can accept operands; high only in IDLE
op_a  input  W  operand A, unsigned or two's complement
op_b  input  W  operand B
cin  input  1  carry-in for add mode; ignored when sub=1
sub  input  1  0 = A+B+cin, 1 = A-B
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
sum  output  W  result bits [W-1:0]
cout  output  1  final carry-out; in sub mode 1 = no borrow (A>=B unsigned)
overflow  output  1  signed two's-complement overflow

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, out_valid=0, sum=0, cout=0, overflow=0. in_ready=0 while rst is high and 1 in the first cycle after reset.
- Reset mid-operation (RUN or DONE): the operation is aborted and its result discarded. The next edge returns to IDLE with all reset values.
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. When in_valid&&in_ready:
  - capture op_a into a_reg.
  - capture b_eff = sub ? ~op_b : op_b into b_reg.
  - set carry_reg = sub ? 1 : cin.
  - set idx=0 and go to RUN.
- RUN: in_ready=0 and out_valid=0.
  - RCA inputs: A=a_reg byte idx, B=b_reg byte idx, Cin=carry_reg.
  - Each edge: write S[7:0] into work byte idx, set carry_reg <= S[8], idx <= idx+1.
  - On the edge that processes idx==NBYTES-1, load the result registers and go to DONE:
    - sum <= full work word, including this byte.
    - cout <= S[8].
    - overflow <= (a_reg[W-1]==b_reg[W-1]) && (S[7]!=a_reg[W-1]).
- DONE: out_valid=1, in_ready=0. On out_ready, go to IDLE and clear out_valid.
  - in_valid is ignored in DONE; there is no same-cycle result/operand overlap.
- Latency: with accept at edge 0, out_valid is high after edge NBYTES. Minimum initiation interval is NBYTES+2 cycles.
- Output stability: sum, cout and overflow change only when DONE is entered (or on reset). They hold through back-pressure, through IDLE, and until the next DONE entry.
- Operand stability: operands are captured at acceptance. Changes on op_a, op_b, sub or cin after acceptance have no effect.
- Widths: the idx counter is $clog2(NBYTES) bits and wraps only via the state change, never modulo within RUN.
- No combinational path from in_valid or out_ready to any output other than through the state registers. in_ready and out_valid are decoded from state only.

Test Plan:
All scenarios use NBYTES=4.
1. Add 0xFFFFFFFF+0x00000001, cin=0 -> out_valid exactly 4 cycles after accept; sum=0x00000000, cout=1, overflow=0 (carry ripples across all byte boundaries).
2. Add 0x7FFFFFFF+0x00000001, cin=0 -> sum=0x80000000, cout=0, overflow=1. Add 0x12345678+0x11111111, cin=1 -> sum=0x2345678A, cout=0.
3. Sub 0x00000005-0x00000007 with cin=1 (must be ignored) -> sum=0xFFFFFFFE, cout=0, overflow=0. Sub 0x80000000-0x00000001 -> sum=0x7FFFFFFF, cout=1, overflow=1.
4. Back-pressure: out_ready held low 5 cycles after out_valid, with in_valid=1 and new operands driven -> out_valid, sum, cout and overflow held, in_ready=0, new operands not captured. Raise out_ready -> IDLE next cycle; the subsequent op computes correctly.
5. Assert rst during the second RUN cycle -> next cycle out_valid=0, sum=0, cout=0, overflow=0; in_ready=1 the cycle after rst drops. A following add 0x000000FF+0x00000001 gives sum=0x00000100.
6. Back-to-back ops with in_valid and out_ready tied high -> accepts spaced exactly NBYTES+2 cycles apart. Each result matches a scoreboard computed as {cout,sum} = A + (sub ? ~B+1 : B+cin).
